// File: rtl/dma_bypass_status_reader.sv
// Host read-back path for DMA bypass completions: buffers get/put completion
// records and the latest receive counter, served through a pop-on-read BRAM port.

module dma_bypass_status_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [W-1:0]             push_data,
  input  logic                     pop_req,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // ready comes from the registered count, so a pop never frees a slot in the same cycle
  assign push_ready = !rst && (count != CNT_W'(DEPTH));
  assign push       = push_valid && push_ready;
  assign pop        = pop_req && (count != '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

module dma_bypass_status_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          pcie_clk,
  input  logic          pcie_reset,
  input  logic          bram_en_a,
  input  logic          bram_we_a,
  input  logic [15:0]   bram_addr_a,
  input  logic [511:0]  bram_wrdata_a,
  output logic [511:0]  bram_rddata_a,
  // Streams: a beat transfers on the rising edge where valid && ready are both high;
  // data must be stable while valid is high, and ready never depends on valid.
  input  logic          s_axis_recv_write_cnt_valid,
  output logic          s_axis_recv_write_cnt_ready,
  input  logic [79:0]   s_axis_recv_write_cnt_data,
  input  logic          s_axis_get_data_done_valid,
  output logic          s_axis_get_data_done_ready,
  input  logic [159:0]  s_axis_get_data_done_data,
  input  logic          s_axis_put_data_done_valid,
  output logic          s_axis_put_data_done_ready,
  input  logic [159:0]  s_axis_put_data_done_data
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]       slot;
  logic             rd;
  logic             wr;
  logic [79:0]      recv_latest;
  logic [15:0]      recv_total;
  logic [15:0]      get_total;
  logic [15:0]      put_total;
  logic [159:0]     get_head;
  logic [159:0]     put_head;
  logic [CNT_W-1:0] get_count;
  logic [CNT_W-1:0] put_count;
  logic             get_push;
  logic             put_push;
  logic             recv_push;
  logic             unused_ok;

  assign slot      = bram_addr_a[11:6];
  assign rd        = bram_en_a && !bram_we_a;
  assign wr        = bram_en_a && bram_we_a;
  assign unused_ok = ^{bram_addr_a[15:12], bram_addr_a[5:0], bram_wrdata_a[511:1]};

  assign s_axis_recv_write_cnt_ready = !pcie_reset;
  assign recv_push = s_axis_recv_write_cnt_valid && s_axis_recv_write_cnt_ready;
  assign get_push  = s_axis_get_data_done_valid && s_axis_get_data_done_ready;
  assign put_push  = s_axis_put_data_done_valid && s_axis_put_data_done_ready;

  dma_bypass_status_fifo #(.DEPTH(FIFO_DEPTH), .W(160)) u_get_fifo (
    .clk        (pcie_clk),
    .rst        (pcie_reset),
    .push_valid (s_axis_get_data_done_valid),
    .push_ready (s_axis_get_data_done_ready),
    .push_data  (s_axis_get_data_done_data),
    .pop_req    (rd && slot == 6'd9),
    .head       (get_head),
    .count      (get_count)
  );

  dma_bypass_status_fifo #(.DEPTH(FIFO_DEPTH), .W(160)) u_put_fifo (
    .clk        (pcie_clk),
    .rst        (pcie_reset),
    .push_valid (s_axis_put_data_done_valid),
    .push_ready (s_axis_put_data_done_ready),
    .push_data  (s_axis_put_data_done_data),
    .pop_req    (rd && slot == 6'd10),
    .head       (put_head),
    .count      (put_count)
  );

  always_ff @(posedge pcie_clk) begin
    if (pcie_reset) begin
      bram_rddata_a <= '0;
      recv_latest   <= '0;
      recv_total    <= '0;
      get_total     <= '0;
      put_total     <= '0;
    end else begin
      if (recv_push) recv_latest <= s_axis_recv_write_cnt_data;
      // a clear in the same cycle as an accepted beat wins
      if (wr && slot == 6'd11 && bram_wrdata_a[0]) begin
        recv_total <= '0;
        get_total  <= '0;
        put_total  <= '0;
      end else begin
        recv_total <= recv_total + 16'(recv_push);
        get_total  <= get_total + 16'(get_push);
        put_total  <= put_total + 16'(put_push);
      end
      if (rd) begin
        case (slot)
          6'd8:    bram_rddata_a <= {432'b0, recv_latest};
          6'd9:    bram_rddata_a <= (get_count != '0) ? {1'b1, 351'b0, get_head} : '0;
          6'd10:   bram_rddata_a <= (put_count != '0) ? {1'b1, 351'b0, put_head} : '0;
          6'd11:   bram_rddata_a <= {448'b0, recv_total, put_total, get_total,
                                     8'(put_count), 8'(get_count)};
          default: bram_rddata_a <= '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dma_bypass_status_reader.sv
// Directed bench for dma_bypass_status_reader: reset, FIFO order, full back-pressure,
// continuous push/pop across pointer wrap, recv/status/clear and mid-run reset.

module tb_dma_bypass_status_reader;
  logic          pcie_clk = 1'b0;
  logic          pcie_reset = 1'b1;
  logic          bram_en_a = 1'b0;
  logic          bram_we_a = 1'b0;
  logic [15:0]   bram_addr_a = '0;
  logic [511:0]  bram_wrdata_a = '0;
  logic [511:0]  bram_rddata_a;
  logic          recv_valid = 1'b0;
  logic          recv_ready;
  logic [79:0]   recv_data = '0;
  logic          get_valid = 1'b0;
  logic          get_ready;
  logic [159:0]  get_data = '0;
  logic          put_valid = 1'b0;
  logic          put_ready;
  logic [159:0]  put_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dma_bypass_status_reader #(.FIFO_DEPTH(4)) dut (
    .pcie_clk                    (pcie_clk),
    .pcie_reset                  (pcie_reset),
    .bram_en_a                   (bram_en_a),
    .bram_we_a                   (bram_we_a),
    .bram_addr_a                 (bram_addr_a),
    .bram_wrdata_a               (bram_wrdata_a),
    .bram_rddata_a               (bram_rddata_a),
    .s_axis_recv_write_cnt_valid (recv_valid),
    .s_axis_recv_write_cnt_ready (recv_ready),
    .s_axis_recv_write_cnt_data  (recv_data),
    .s_axis_get_data_done_valid  (get_valid),
    .s_axis_get_data_done_ready  (get_ready),
    .s_axis_get_data_done_data   (get_data),
    .s_axis_put_data_done_valid  (put_valid),
    .s_axis_put_data_done_ready  (put_ready),
    .s_axis_put_data_done_data   (put_data)
  );

  // clock/reset block
  always #5 pcie_clk = ~pcie_clk;

  // driver tasks: inputs change on the falling edge, outputs sampled there too
  task automatic do_read(input logic [5:0] slot, output logic [511:0] d);
    @(negedge pcie_clk);
    bram_en_a = 1'b1; bram_we_a = 1'b0; bram_addr_a = {4'b0, slot, 6'b0};
    @(negedge pcie_clk);
    bram_en_a = 1'b0;
    d = bram_rddata_a;
  endtask

  task automatic do_write(input logic [5:0] slot, input logic bit0);
    @(negedge pcie_clk);
    bram_en_a = 1'b1; bram_we_a = 1'b1; bram_addr_a = {4'b0, slot, 6'b0};
    bram_wrdata_a = {511'b0, bit0};
    @(negedge pcie_clk);
    bram_en_a = 1'b0; bram_we_a = 1'b0; bram_wrdata_a = '0;
  endtask

  // sel 0 = get stream, 1 = put stream; waits for ready with a bounded budget
  task automatic push_rec(input bit sel, input logic [159:0] d);
    int n;
    @(negedge pcie_clk);
    n = 0;
    if (sel) begin put_valid = 1'b1; put_data = d; end
    else     begin get_valid = 1'b1; get_data = d; end
    while (!(sel ? put_ready : get_ready) && n < 20) begin
      @(negedge pcie_clk);
      n++;
    end
    n_cmp++;
    if (n >= 20) begin
      n_bad++;
      $display("FAIL push_timeout sel=%0d: ready stayed %0b, required 1", sel, 1'b0);
    end
    @(negedge pcie_clk);
    get_valid = 1'b0; put_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [511:0] d;
    for (int i = 0; i < 3; i++) begin
      @(negedge pcie_clk);
      n_cmp++;
      if ({get_ready, put_ready, recv_ready} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_ready: got %b, required 000", {get_ready, put_ready, recv_ready});
      end
      n_cmp++;
      if (bram_rddata_a !== '0) begin
        n_bad++;
        $display("FAIL reset_rddata: got %h, required 0", bram_rddata_a[63:0]);
      end
    end
    pcie_reset = 1'b0;
    #1;
    n_cmp++;
    if ({get_ready, put_ready, recv_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL post_reset_ready: got %b, required 111", {get_ready, put_ready, recv_ready});
    end
    for (int s = 8; s <= 11; s++) begin
      do_read(6'(s), d);
      n_cmp++;
      if (d !== '0) begin
        n_bad++;
        $display("FAIL reset_slot%0d: got %h, required 0", s, d[79:0]);
      end
    end
  endtask

  task automatic test_get_order();
    logic [511:0] d;
    logic [159:0] recs [3];
    recs[0] = 160'hA1; recs[1] = 160'hA2; recs[2] = 160'hA3;
    for (int i = 0; i < 3; i++) push_rec(1'b0, recs[i]);
    for (int i = 0; i < 4; i++) begin
      do_read(6'd9, d);
      n_cmp++;
      if (i < 3 && d !== {1'b1, 351'b0, recs[i]}) begin
        n_bad++;
        $display("FAIL get_pop%0d: got %b/%h, required 1/%h", i, d[511], d[159:0], recs[i]);
      end else if (i == 3 && d !== '0) begin
        n_bad++;
        $display("FAIL get_empty: got %b/%h, required 0", d[511], d[159:0]);
      end
    end
    do_read(6'd11, d);
    n_cmp++;
    if (d[31:16] !== 16'd3 || d[7:0] !== 8'd0) begin
      n_bad++;
      $display("FAIL get_status: total %0d count %0d, required 3 and 0", d[31:16], d[7:0]);
    end
  endtask

  task automatic test_put_full();
    logic [511:0] d;
    logic [159:0] recs [5];
    for (int i = 0; i < 4; i++) recs[i] = 160'hB0 + 160'(i);
    recs[4] = 160'h55;
    for (int i = 0; i < 4; i++) push_rec(1'b1, recs[i]);
    @(negedge pcie_clk);
    put_valid = 1'b1; put_data = recs[4];
    n_cmp++;
    if (put_ready !== 1'b0) begin
      n_bad++; $display("FAIL put_full_ready: got %b, required 0", put_ready);
    end
    @(negedge pcie_clk);
    n_cmp++;
    if (put_ready !== 1'b0) begin
      n_bad++; $display("FAIL put_held_ready: got %b, required 0", put_ready);
    end
    // pop while the 5th beat is still offered; ready stays low this cycle
    bram_en_a = 1'b1; bram_we_a = 1'b0; bram_addr_a = {4'b0, 6'd10, 6'b0};
    @(negedge pcie_clk);
    bram_en_a = 1'b0;
    n_cmp++;
    if (bram_rddata_a !== {1'b1, 351'b0, recs[0]}) begin
      n_bad++; $display("FAIL put_pop_head: got %h, required %h", bram_rddata_a[159:0], recs[0]);
    end
    n_cmp++;
    if (put_ready !== 1'b1) begin
      n_bad++; $display("FAIL put_ready_after_pop: got %b, required 1", put_ready);
    end
    @(negedge pcie_clk);
    put_valid = 1'b0;
    n_cmp++;
    if (put_ready !== 1'b0) begin
      n_bad++; $display("FAIL put_refull_ready: got %b, required 0", put_ready);
    end
    do_read(6'd11, d);
    n_cmp++;
    if (d[15:8] !== 8'd4 || d[47:32] !== 16'd5) begin
      n_bad++;
      $display("FAIL put_status: count %0d total %0d, required 4 and 5", d[15:8], d[47:32]);
    end
    for (int i = 1; i < 5; i++) begin
      do_read(6'd10, d);
      n_cmp++;
      if (d !== {1'b1, 351'b0, recs[i]}) begin
        n_bad++;
        $display("FAIL put_drain%0d: got %b/%h, required 1/%h", i, d[511], d[159:0], recs[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] exp_q[$];
    logic [159:0] e;
    int sent = 0;
    int got = 0;
    for (int cyc = 0; cyc < 40 && got < 20; cyc++) begin
      @(negedge pcie_clk);
      if (cyc == 1) begin
        n_cmp++;
        if (bram_rddata_a !== '0) begin
          n_bad++;
          $display("FAIL b2b_first_empty: got %h, required 0", bram_rddata_a[159:0]);
        end
      end else if (cyc > 1 && bram_rddata_a[511]) begin
        n_cmp++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 160'hx;
        if (bram_rddata_a !== {1'b1, 351'b0, e}) begin
          n_bad++;
          $display("FAIL b2b_rec%0d: got %h, required %h", got, bram_rddata_a[159:0], e);
        end
        got++;
      end
      if (sent < 20) begin
        get_valid = 1'b1;
        get_data  = {5{32'hC000_0000 + 32'(sent)}};
        if (get_ready) begin
          exp_q.push_back(get_data);
          sent++;
        end
      end else begin
        get_valid = 1'b0;
      end
      bram_en_a = 1'b1; bram_we_a = 1'b0; bram_addr_a = {4'b0, 6'd9, 6'b0};
    end
    @(negedge pcie_clk);
    bram_en_a = 1'b0; get_valid = 1'b0;
    n_cmp++;
    if (got != 20 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_total: got %0d left %0d, required 20 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_recv_clear();
    logic [511:0] d;
    logic [511:0] held;
    @(negedge pcie_clk);
    recv_valid = 1'b1; recv_data = 80'h10;
    @(negedge pcie_clk);
    recv_data = 80'h20;
    @(negedge pcie_clk);
    recv_valid = 1'b0;
    do_read(6'd8, d);
    n_cmp++;
    if (d !== {432'b0, 80'h20}) begin
      n_bad++; $display("FAIL recv_latest: got %h, required 20", d[79:0]);
    end
    do_read(6'd11, d);
    n_cmp++;
    if (d[63:48] !== 16'd2 || d[31:16] !== 16'd23) begin
      n_bad++;
      $display("FAIL recv_status: recv %0d get %0d, required 2 and 23", d[63:48], d[31:16]);
    end
    push_rec(1'b0, 160'hD1);
    push_rec(1'b0, 160'hD2);
    held = bram_rddata_a;
    do_write(6'd11, 1'b1);
    n_cmp++;
    if (bram_rddata_a !== held) begin
      n_bad++; $display("FAIL write_rddata: got %h, required %h", bram_rddata_a[63:0], held[63:0]);
    end
    do_read(6'd11, d);
    n_cmp++;
    if (d !== 512'd2) begin
      n_bad++; $display("FAIL clear_status: got %h, required 2", d[63:0]);
    end
    do_read(6'd8, d);
    n_cmp++;
    if (d !== {432'b0, 80'h20}) begin
      n_bad++; $display("FAIL clear_recv_kept: got %h, required 20", d[79:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    @(negedge pcie_clk);
    pcie_reset = 1'b1;
    bram_en_a = 1'b1; bram_we_a = 1'b0; bram_addr_a = {4'b0, 6'd9, 6'b0};
    @(negedge pcie_clk);
    pcie_reset = 1'b0; bram_en_a = 1'b0;
    n_cmp++;
    if (bram_rddata_a !== '0) begin
      n_bad++; $display("FAIL rst_cycle_read: got %h, required 0", bram_rddata_a[159:0]);
    end
    do_read(6'd9, d);
    n_cmp++;
    if (d !== '0) begin
      n_bad++; $display("FAIL rst_get_empty: got %h, required 0", d[159:0]);
    end
    do_read(6'd11, d);
    n_cmp++;
    if (d !== '0) begin
      n_bad++; $display("FAIL rst_status: got %h, required 0", d[63:0]);
    end
    do_read(6'd8, d);
    n_cmp++;
    if (d !== '0) begin
      n_bad++; $display("FAIL rst_recv: got %h, required 0", d[79:0]);
    end
  endtask

  initial begin
    test_reset();
    test_get_order();
    test_put_full();
    test_back_to_back();
    test_recv_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_bypass_status_reader.md
# dma_bypass_status_reader

Host-facing read-back path for the DMA bypass control region: the return direction of the command-issue logic that turns host BRAM writes into `axis_meta` commands. It accepts completion and status records from the data-movement engines on `axis_meta` slave streams, buffers them per source, and serves them to the host through the same 512-bit BRAM-style port using registered, pop-on-read semantics. It sits on the PCIe clock domain next to the command issuer and shares its address decode on `bram_addr_a[11:6]`.

## Interface
- `FIFO_DEPTH`, 4: entries per completion FIFO; power of two, 2..16.
- `pcie_clk`  in  1  sole clock; all logic on its rising edge.
- `pcie_reset`  in  1  reset, synchronous, active-high.
- `bram_en_a`  in  1  port access strobe.
- `bram_we_a`  in  1  1 = write access, 0 = read access.
- `bram_addr_a`  in  16  byte address; slot = `bram_addr_a[11:6]`.
- `bram_wrdata_a`  in  512  write data; only bit 0 is used, and only in slot 11.
- `bram_rddata_a`  out  512  registered read data.
- `s_axis_recv_write_cnt`  axis_meta.slave  80  latest receive-side write counter; always ready.
- `s_axis_get_data_done`  axis_meta.slave  160  get-command completion records.
- `s_axis_put_data_done`  axis_meta.slave  160  put-command completion records.

## Operation
- Read: `bram_en_a && !bram_we_a`. Slot is decoded from `bram_addr_a[11:6]`. Result appears on `bram_rddata_a` the next cycle and holds until the next read.
- Slot 8: `{432'b0, recv_latest[79:0]}`. Non-destructive.
- Slot 9: returns the get-FIFO head.
  - Non-empty: `{1'b1, 351'b0, head[159:0]}` and the head is popped.
  - Empty: all zero, no pop.
- Slot 10: same behaviour as slot 9, applied to the put FIFO.
- Slot 11: status word, non-destructive.
  - [7:0] get-FIFO count.
  - [15:8] put-FIFO count.
  - [31:16] get records accepted, 16-bit wrapping.
  - [47:32] put records accepted, 16-bit wrapping.
  - [63:48] recv-latest update count, 16-bit wrapping.
  - Remaining bits are zero.
- Any other slot reads all zero.
- Write: `bram_en_a && bram_we_a`.
  - Slot 11 with `bram_wrdata_a[0]=1` clears the three 16-bit totals. FIFOs and recv-latest are unaffected.
  - All other writes are ignored by this block.
  - A write never changes `bram_rddata_a`.
- Recv stream:
  - `ready` is constantly 1 outside reset.
  - Each valid beat overwrites `recv_latest` and increments its update count.
- Completion FIFOs (get and put, independent):
  - `ready = !pcie_reset && count != FIFO_DEPTH`, where `count` is the registered count.
  - A beat is pushed on `valid && ready`.
  - Read and write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth.
  - `count` is `log2(FIFO_DEPTH)+1` bits, zero-extended into the status byte.
- Simultaneous push and pop on a non-empty FIFO: both take effect and `count` is unchanged.
- Push into an empty FIFO in the same cycle as a read of that slot: the read returns all zero, the entry is stored, and `count` becomes 1.
- Full FIFO popped in the same cycle as a `valid` beat: `ready` was 0 that cycle, so the beat is not taken. It is accepted the following cycle.

## Timing
- Reset values (every output and state element):
  - `bram_rddata_a` = 0.
  - All `ready` = 0 while `pcie_reset` is high.
  - FIFO pointers and counts = 0.
  - `recv_latest` = 0 and all totals = 0.
- Reset mid-operation: buffered records are discarded. A read issued in the reset cycle returns 0.
- Recv stream `ready` rises the first cycle after `pcie_reset` deasserts.
- Read latency: exactly 1 cycle.
- Back-to-back reads every cycle are supported. Each read of slot 9 or 10 pops exactly one entry.
- Status read latency: slot 11 reflects state after all pushes and pops of the cycles before the read cycle.
- Push visibility: a record accepted at edge N is visible to a read issued at cycle N+1, returned at N+2.
- Throughput: one push per stream per cycle and one pop per cycle.

## Test plan
- Reset check: assert `pcie_reset` 3 cycles, then read slots 8–11 -> all return 0; get/put `ready` = 1 after reset.
- Push get records 0xA1, 0xA2, 0xA3, then read slot 9 four times -> `{1,..,0xA1}`, `{1,..,0xA2}`, `{1,..,0xA3}`, then 0. Slot 11 [31:16] = 3 and [7:0] = 0.
- Fill the put FIFO with 4 records (`FIFO_DEPTH`=4) while `valid` stays high -> `ready` = 0 and the 5th record is held. Pop once -> the 5th record is accepted the next cycle and count returns to 4.
- Drive continuous pushes while reading slot 9 every cycle over 20 records -> records return in order with no loss or duplication across pointer wrap.
- Drive recv updates 0x10 then 0x20, then read slot 8 -> 0x20; [63:48] = 2. Write slot 11 with data bit 0 = 1 -> totals read back as 0 and FIFO counts are unchanged.
- Reset with 2 get records queued -> a slot 9 read afterwards returns 0 and `count` = 0.
